// File: rtl/multi_digit_counter_display.sv
// N-digit hex/BCD up/down counter with an auto-tick prescaler and a
// time-multiplexed, active-low seven-segment scan driver.
module multi_digit_counter_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100_000,
    parameter int AUTO_DIV   = 100_000_000,
    parameter int LZ_BLANK   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc_pulse,
    input  logic                    dec_pulse,
    input  logic                    auto_en,
    input  logic                    auto_dir,
    input  logic                    bcd_mode,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int CNT_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int AUTO_W = $clog2(AUTO_DIV);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      r_count;
    logic                  r_wrap;
    logic                  r_bcdPrev;
    logic [AUTO_W-1:0]     r_autoCnt;
    logic [SCAN_W-1:0]     r_scanCnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic                  w_tick;
    logic                  w_up;
    logic                  w_down;
    logic                  w_bcdChange;
    logic [3:0]            w_digitMax;
    logic [CNT_W-1:0]      w_incCount;
    logic                  w_incCarry;
    logic [CNT_W-1:0]      w_decCount;
    logic                  w_decBorrow;
    logic [NUM_DIGITS-1:0] w_lzBlank;
    logic [3:0]            w_digitSel;
    logic                  w_blankSel;

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // Auto prescaler is parked at zero while disabled so the first tick is a full period away.
    always_ff @(posedge clk) begin
        if (reset || !auto_en) begin
            r_autoCnt <= '0;
        end else if (r_autoCnt == AUTO_LAST) begin
            r_autoCnt <= '0;
        end else begin
            r_autoCnt <= r_autoCnt + AUTO_W'(1);
        end
    end

    assign w_tick      = auto_en && (r_autoCnt == AUTO_LAST);
    assign w_bcdChange = bcd_mode ^ r_bcdPrev;
    assign w_digitMax  = bcd_mode ? 4'd9 : 4'd15;

    always_comb begin
        w_up   = 1'b0;
        w_down = 1'b0;
        if (auto_en) begin
            w_up   = w_tick & ~auto_dir;
            w_down = w_tick & auto_dir;
        end else begin
            w_up   = inc_pulse & ~dec_pulse;
            w_down = dec_pulse & ~inc_pulse;
        end
    end

    // Ripple carry/borrow through all digits; the final carry/borrow is the wrap condition.
    always_comb begin
        w_incCount  = r_count;
        w_incCarry  = 1'b1;
        w_decCount  = r_count;
        w_decBorrow = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_incCarry) begin
                if (r_count[4*k +: 4] == w_digitMax) begin
                    w_incCount[4*k +: 4] = 4'd0;
                end else begin
                    w_incCount[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    w_incCarry           = 1'b0;
                end
            end
            if (w_decBorrow) begin
                if (r_count[4*k +: 4] == 4'd0) begin
                    w_decCount[4*k +: 4] = w_digitMax;
                end else begin
                    w_decCount[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
                    w_decBorrow          = 1'b0;
                end
            end
        end
    end

    // A mode change clears the count and swallows any step arriving in the same cycle,
    // so an out-of-range BCD digit can never appear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_wrap    <= 1'b0;
            r_bcdPrev <= bcd_mode;
        end else begin
            r_bcdPrev <= bcd_mode;
            r_wrap    <= 1'b0;
            if (w_bcdChange) begin
                r_count <= '0;
            end else if (w_up) begin
                r_count <= w_incCount;
                r_wrap  <= w_incCarry;
            end else if (w_down) begin
                r_count <= w_decCount;
                r_wrap  <= w_decBorrow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scanCnt <= '0;
            r_idx     <= '0;
        end else if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_scanCnt <= r_scanCnt + SCAN_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic allZeroAbove;
        allZeroAbove = 1'b1;
        w_lzBlank    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allZeroAbove = allZeroAbove && (r_count[4*k +: 4] == 4'd0);
            w_lzBlank[k] = allZeroAbove && (k != 0) && (LZ_BLANK != 0);
        end
    end

    always_comb begin
        w_digitSel = r_count[3:0];
        w_blankSel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digitSel = r_count[4*k +: 4];
                w_blankSel = w_lzBlank[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_blankSel ? 7'h7F : segDecode(w_digitSel);
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: directed steps plus random traffic,
// checked every cycle against an arithmetic model of count, wrap and scan.
module tb_multi_digit_counter_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int AD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        incPulse = 1'b0;
    logic        decPulse = 1'b0;
    logic        autoEn = 1'b0;
    logic        autoDir = 1'b0;
    logic        bcdMode = 1'b0;
    logic [15:0] count, count2;
    logic        wrap, wrap2;
    logic [3:0]  an, an2;
    logic [6:0]  seg, seg2;

    int tests = 0;
    int fails = 0;

    logic [15:0] mCount = '0;
    logic        mWrap = 1'b0;
    logic [3:0]  mAn = 4'hF;
    logic [6:0]  mSeg = 7'h7F;
    logic [6:0]  mSeg2 = 7'h7F;
    int          mAutoCyc = 0;
    int          mScanK = 0;
    logic        prevBcd = 1'b0;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    multi_digit_counter_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .AUTO_DIV(AD), .LZ_BLANK(0)
    ) dut (
        .clk(clk), .reset(reset), .inc_pulse(incPulse), .dec_pulse(decPulse),
        .auto_en(autoEn), .auto_dir(autoDir), .bcd_mode(bcdMode),
        .count(count), .wrap(wrap), .an(an), .seg(seg)
    );

    multi_digit_counter_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .AUTO_DIV(AD), .LZ_BLANK(1)
    ) dutLz (
        .clk(clk), .reset(reset), .inc_pulse(incPulse), .dec_pulse(decPulse),
        .auto_en(autoEn), .auto_dir(autoDir), .bcd_mode(bcdMode),
        .count(count2), .wrap(wrap2), .an(an2), .seg(seg2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int toDec(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] toBcd(input int d);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs as sampled at that edge.
    task automatic modelEdge();
        int idx;
        int digitVal;
        int d;
        logic tick, up, down, change;
        if (reset) begin
            mCount   = '0;
            mWrap    = 1'b0;
            mAn      = 4'hF;
            mSeg     = 7'h7F;
            mSeg2    = 7'h7F;
            mAutoCyc = 0;
            mScanK   = 0;
            prevBcd  = bcdMode;
        end else begin
            idx      = (mScanK / SD) % ND;
            digitVal = int'((mCount >> (4 * idx)) & 16'hF);
            mAn      = ~(4'b0001 << idx);
            mSeg     = segTable[digitVal];
            mSeg2    = (idx > 0 && (mCount >> (4 * idx)) == 16'h0) ? 7'h7F : segTable[digitVal];
            mScanK++;

            tick     = autoEn && (mAutoCyc == AD - 1);
            mAutoCyc = autoEn ? (mAutoCyc + 1) % AD : 0;
            up       = autoEn ? (tick && !autoDir) : (incPulse && !decPulse);
            down     = autoEn ? (tick && autoDir)  : (decPulse && !incPulse);
            change   = (bcdMode != prevBcd);
            prevBcd  = bcdMode;

            mWrap = 1'b0;
            if (change) begin
                mCount = '0;
            end else if (up) begin
                if (bcdMode) begin
                    d      = toDec(mCount);
                    mWrap  = (d == 9999);
                    mCount = toBcd((d + 1) % 10000);
                end else begin
                    mWrap  = (mCount == 16'hFFFF);
                    mCount = mCount + 16'd1;
                end
            end else if (down) begin
                if (bcdMode) begin
                    d      = toDec(mCount);
                    mWrap  = (d == 0);
                    mCount = toBcd((d + 9999) % 10000);
                end else begin
                    mWrap  = (mCount == 16'h0000);
                    mCount = mCount - 16'd1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic dec);
        incPulse = inc;
        decPulse = dec;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("count", count, mCount);
        checkOutput("wrap", 16'(wrap), 16'(mWrap));
        checkOutput("an", 16'(an), 16'(mAn));
        checkOutput("seg", 16'(seg), 16'(mSeg));
        checkOutput("an_lz", 16'(an2), 16'(mAn));
        checkOutput("seg_lz", 16'(seg2), 16'(mSeg2));
        incPulse = 1'b0;
        decPulse = 1'b0;
    endtask

    initial begin
        logic [15:0] prevCount;
        int changes;
        int lastChange;
        logic found;

        $display("[TB] reset");
        reset = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_count", count, 16'h0000);
        checkOutput("reset_an", 16'(an), 16'hF);
        checkOutput("reset_seg", 16'(seg), 16'h7F);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("release_an", 16'(an), 16'hE);
        checkOutput("release_seg", 16'(seg), 16'h40);

        $display("[TB] hex wrap");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("hex_fffe", count, 16'hFFFE);
        applyStimulus(1'b1, 1'b0);
        checkOutput("hex_ffff", count, 16'hFFFF);
        checkOutput("hex_ffff_nowrap", 16'(wrap), 16'h0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("hex_0000", count, 16'h0000);
        checkOutput("hex_wrap_up", 16'(wrap), 16'h1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("wrap_one_cycle", 16'(wrap), 16'h0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("hex_wrap_down", count, 16'hFFFF);
        checkOutput("hex_wrap_down_flag", 16'(wrap), 16'h1);

        $display("[TB] bcd");
        repeat (16'h1235) applyStimulus(1'b1, 1'b0);
        checkOutput("hex_1234", count, 16'h1234);
        bcdMode = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("bcd_clear", count, 16'h0000);
        checkOutput("bcd_clear_nowrap", 16'(wrap), 16'h0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("bcd_9999", count, 16'h9999);
        applyStimulus(1'b1, 1'b0);
        checkOutput("bcd_wrap_up", count, 16'h0000);
        checkOutput("bcd_wrap_flag", 16'(wrap), 16'h1);
        repeat (100) applyStimulus(1'b1, 1'b0);
        checkOutput("bcd_0100", count, 16'h0100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("bcd_0099", count, 16'h0099);
        repeat (57) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("inc_dec_hold", count, 16'h0042);
        checkOutput("inc_dec_nowrap", 16'(wrap), 16'h0);

        $display("[TB] auto");
        autoEn     = 1'b1;
        autoDir    = 1'b0;
        prevCount  = count;
        changes    = 0;
        lastChange = -1;
        for (int i = 0; i < 35; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
            if (count !== prevCount) begin
                changes++;
                if (lastChange >= 0) checkOutput("auto_gap", 16'(i - lastChange), 16'd10);
                lastChange = i;
            end
            prevCount = count;
        end
        checkOutput("auto_changes", 16'(changes), 16'd3);
        checkOutput("auto_count", count, 16'h0045);
        autoEn = 1'b0;
        reset  = 1'b1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        autoEn  = 1'b1;
        autoDir = 1'b1;
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("auto_down_9999", count, 16'h9999);
        checkOutput("auto_down_wrap", 16'(wrap), 16'h1);
        autoEn = 1'b0;

        $display("[TB] scan");
        bcdMode = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (165) applyStimulus(1'b1, 1'b0);
        checkOutput("scan_00a5", count, 16'h00A5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (an === 4'hB) begin
                found = 1'b1;
                checkOutput("scan_digit2", 16'(seg), 16'h40);
                checkOutput("lz_digit2", 16'(seg2), 16'h7F);
            end
        end
        checkOutput("scan_saw_digit2", 16'(found), 16'h1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        repeat (20) applyStimulus(1'b0, 1'b0);

        $display("[TB] mid-operation reset");
        autoEn  = 1'b1;
        autoDir = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (mAutoCyc == 7 && ((mScanK / SD) % ND) == 2) found = 1'b1;
        end
        checkOutput("midreset_reached", 16'(found), 16'h1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("midreset_count", count, 16'h0000);
        checkOutput("midreset_an", 16'(an), 16'hF);
        checkOutput("midreset_seg", 16'(seg), 16'h7F);
        reset = 1'b0;
        repeat (9) applyStimulus(1'b0, 1'b0);
        checkOutput("first_tick_not_early", count, 16'h0000);
        applyStimulus(1'b0, 1'b0);
        checkOutput("first_tick_on_time", count, 16'h0001);

        $display("[TB] random");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) autoEn = ~autoEn;
            if ($urandom_range(0, 9) == 0) autoDir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) bcdMode = ~bcdMode;
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
